rider_balance_seq: RTL and testbench

- Rider-presence and steering sequencer for the balance controller.
- Evaluates the left and right load-cell readings on each valid inertial/ADC sample.
- Drives pwr_up (soft-start gate), rider_off (integrator clear) and en_steer into the PID and steering datapath.
- Holds off steering until the rider has been balanced for a settle interval.

---
 rtl/segway_pkg.sv | 17 +
 rtl/settle_timer.sv | 35 +++
 rtl/rider_balance_seq.sv | 115 +++++++++++
 tb/tb_rider_balance_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared types and defaults for the segway balance-controller blocks.
package segway_pkg;

  localparam int LD_W  = 12;
  localparam int SUM_W = 13;

  localparam logic [SUM_W-1:0] DEF_MIN_RIDER_WT = 13'h200;
  localparam logic [SUM_W-1:0] DEF_WT_HYST      = 13'h040;
  localparam int               DEF_TMR_W        = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    STEER = 2'b10
  } seq_state_t;

endpackage

// File: rtl/settle_timer.sv
// Saturating up-counter that flags expiry when it reaches all ones.
// Build macro RIDER_SEQ_FAST_SIM_EN narrows the counter to at most 15 bits
// so the settle interval is short enough for simulation.
module settle_timer #(
  parameter int TMR_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

`ifdef RIDER_SEQ_FAST_SIM_EN
  localparam int CNT_W = (TMR_W < 15) ? TMR_W : 15;
`else
  localparam int CNT_W = TMR_W;
`endif

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] tmr;

  assign expired = &tmr;

  // Count while enabled, hold at all ones, clear on request or reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tmr <= '0;
    end else if (enable && !expired) begin
      tmr <= tmr + ONE;
    end
  end

endmodule

// File: rtl/rider_balance_seq.sv
// Rider-presence and steering sequencer: decides from the load cells when
// to power up the balance loop, clear the integrator and enable steering.
//
// state | meaning
// IDLE  | no rider; integrator held clear
// WAIT  | rider on, settling; steering held off until timer expires
// STEER | rider balanced and settled; steering enabled
//
// Optional build macro: RIDER_SEQ_FAST_SIM_EN (shortened settle timer).
module rider_balance_seq
  import segway_pkg::*;
#(
  parameter logic [SUM_W-1:0] MIN_RIDER_WT = DEF_MIN_RIDER_WT,
  parameter logic [SUM_W-1:0] WT_HYST      = DEF_WT_HYST,
  parameter int               TMR_W        = DEF_TMR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            pwr_up,
  output logic            rider_off,
  output logic            en_steer,
  output logic [1:0]      seq_state
);

  localparam logic [SUM_W-1:0] ON_THR  = MIN_RIDER_WT;
  localparam logic [SUM_W-1:0] OFF_THR = MIN_RIDER_WT - WT_HYST;

  seq_state_t state_q, state_d;

  logic [SUM_W-1:0] sum, diff, qtr, frac15;
  logic             rider_on, rider_gone, unbal_wait, unbal_steer;
  logic             tmr_clr, tmr_en, tmr_expired;

  // Zero-extend before adding so the worst case 0xFFF+0xFFF cannot wrap.
  assign sum    = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff   = (lft_ld >= rght_ld) ? ({1'b0, lft_ld} - {1'b0, rght_ld})
                                      : ({1'b0, rght_ld} - {1'b0, lft_ld});
  assign qtr    = sum >> 2;
  assign frac15 = sum - (sum >> 4);

  assign rider_on    = sum > ON_THR;
  assign rider_gone  = sum < OFF_THR;
  assign unbal_wait  = diff > qtr;
  assign unbal_steer = diff > frac15;

  assign tmr_en = (state_q == WAIT);

  settle_timer #(
    .TMR_W(TMR_W)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, timer clear and Moore output decode.
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    pwr_up    = 1'b0;
    rider_off = 1'b0;
    en_steer  = 1'b0;
    seq_state = state_q;

    case (state_q)
      IDLE: begin
        rider_off = 1'b1;
        if (vld && rider_on) begin
          state_d = WAIT;
          tmr_clr = 1'b1;
        end
      end
      WAIT: begin
        pwr_up = 1'b1;
        // Rider-off beats imbalance; imbalance beats a same-cycle expiry.
        if (vld && rider_gone) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (vld && unbal_wait) begin
          tmr_clr = 1'b1;
        end else if (tmr_expired) begin
          state_d = STEER;
        end
      end
      STEER: begin
        pwr_up   = 1'b1;
        en_steer = 1'b1;
        if (vld && rider_gone) begin
          state_d = IDLE;
        end else if (vld && unbal_steer) begin
          state_d = WAIT;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rider_balance_seq.sv
// Scoreboard bench for rider_balance_seq: a behavioural rider model predicts
// the outputs for every cycle; a monitor pops and compares independently.
module tb_rider_balance_seq;

  localparam int SETTLE_W = 13;
  localparam int SETTLE   = 1 << SETTLE_W;
  localparam int ON_WT    = 'h200;
  localparam int OFF_WT   = 'h200 - 'h040;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        pwr_up, rider_off, en_steer;
  logic [1:0]  seq_state;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  string cur_tag = "reset";

  // Model: mode 0 = no rider, 1 = settling, 2 = steering.
  int m_mode = 0;
  int m_elapsed = 0;

  always #5 clk = ~clk;

  rider_balance_seq #(
    .MIN_RIDER_WT(13'h200),
    .WT_HYST     (13'h040),
    .TMR_W       (SETTLE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .pwr_up   (pwr_up),
    .rider_off(rider_off),
    .en_steer (en_steer),
    .seq_state(seq_state)
  );

  function automatic void model_step(input bit r, input bit v, input int l, input int rr);
    int  sum, diff;
    bit  light, heavy, off_center, foot_up;
    sum        = l + rr;
    diff       = (l > rr) ? (l - rr) : (rr - l);
    heavy      = sum > ON_WT;
    light      = sum < OFF_WT;
    off_center = diff > sum / 4;
    foot_up    = diff > sum - sum / 16;
    if (r) begin
      m_mode = 0;
      m_elapsed = 0;
    end else if (m_mode == 0) begin
      if (v && heavy) begin
        m_mode = 1;
        m_elapsed = 0;
      end
    end else if (m_mode == 1) begin
      if (v && light) begin
        m_mode = 0;
        m_elapsed = 0;
      end else if (v && off_center) begin
        m_elapsed = 0;
      end else if (m_elapsed + 1 == SETTLE) begin
        m_mode = 2;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (v && light) begin
        m_mode = 0;
      end else if (v && foot_up) begin
        m_mode = 1;
        m_elapsed = 0;
      end
    end
  endfunction

  function automatic logic [4:0] model_out();
    logic [1:0] st;
    st = 2'(m_mode);
    return {st, m_mode != 0, m_mode == 0, m_mode == 2};
  endfunction

  task automatic drive(input bit r, input bit v, input int l, input int rr);
    exp_t e;
    @(negedge clk);
    rst     = r;
    vld     = v;
    lft_ld  = 12'(l);
    rght_ld = 12'(rr);
    model_step(r, v, l, rr);
    e.exp = model_out();
    e.tag = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, $urandom_range(0, 4095), $urandom_range(0, 4095));
  endtask

  task automatic settle_to_steer();
    for (int i = 0; i < SETTLE + 4 && m_mode != 2; i++) quiet(1);
  endtask

  // Monitor: one scoreboard entry per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({seq_state, pwr_up, rider_off, en_steer} !== e.exp) begin
          errors++;
          $display("FAIL %s t=%0t actual {st,pwr,roff,en}=%b required=%b",
                   e.tag, $time, {seq_state, pwr_up, rider_off, en_steer}, e.exp);
        end
      end
    end
  end

  // Stimulus: random phase, then the directed sequencing scenarios.
  initial begin
    int l, rr, base;
    cur_tag = "reset";
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);

    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: begin l = $urandom_range(0, 'h1A0); rr = $urandom_range(0, 'h1A0); end
        1: begin base = $urandom_range('hD8, 'h108); l = base; rr = base + $urandom_range(0, 2); end
        2: begin l = 'hFFF; rr = 'hFFF; end
        default: begin l = $urandom_range(0, 'hFFF); rr = $urandom_range(0, 'hFFF); end
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, l, rr);
    end

    cur_tag = "reset_mid";
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);

    cur_tag = "on_boundary";
    drive(0, 1, 'h100, 'h100);
    quiet(2);

    cur_tag = "mount";
    drive(0, 1, 'h180, 'h180);
    quiet(5000);

    cur_tag = "imbalance_restart";
    drive(0, 1, 'h300, 'h080);
    settle_to_steer();
    quiet(3);

    cur_tag = "off_boundary";
    drive(0, 1, 'h0E0, 'h0E0);
    quiet(2);

    cur_tag = "foot_lift";
    drive(0, 1, 'h3F0, 'h010);
    for (int i = 0; i < SETTLE + 4 && m_elapsed + 1 < SETTLE; i++) quiet(1);

    cur_tag = "expiry_vs_imbalance";
    drive(0, 1, 'h300, 'h080);
    settle_to_steer();
    quiet(2);

    cur_tag = "step_off";
    drive(0, 1, 'h0E8, 'h0E8);
    drive(0, 1, 'h080, 'h080);

    cur_tag = "vld_gating";
    quiet(3);

    cur_tag = "full_scale";
    drive(0, 1, 'hFFF, 'hFFF);
    settle_to_steer();
    quiet(2);

    cur_tag = "reset_from_steer";
    drive(1, 0, 'h180, 'h180);
    drive(1, 1, 'h180, 'h180);
    quiet(3);

    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d entries left required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
